// File: rtl/dadda_pkg.sv
// Shared types and constants for the Dadda dot-product engine.
package dadda_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam int unsigned OP_W      = 16;
    localparam int unsigned PROD_W    = 32;
    localparam int unsigned ACC_LIM_W = 128;

    // Largest positive value of a w-bit signed number, zero-extended to ACC_LIM_W.
    function automatic logic [ACC_LIM_W-1:0] acc_max(input int unsigned w);
        return (ACC_LIM_W'(1) << (w - 1)) - ACC_LIM_W'(1);
    endfunction

    // Low w bits hold the most negative w-bit signed value (1 followed by zeros).
    function automatic logic [ACC_LIM_W-1:0] acc_min(input int unsigned w);
        return ~acc_max(w);
    endfunction

endpackage

// File: rtl/dadda16x16.sv
// Combinational 16x16 signed multiplier: Baugh-Wooley partial products,
// Dadda column compression (13,9,6,4,3,2), then a final carry-propagate add.
module dadda16x16
    import dadda_pkg::*;
(
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    output logic [PROD_W-1:0] prod_o
);

    localparam int unsigned NCOL = PROD_W;
    localparam int unsigned NSTG = 6;
    localparam int unsigned MAXA = 12;

    function automatic logic [4:0] stage_h(input int unsigned s);
        case (s)
            0:       return 5'd13;
            1:       return 5'd9;
            2:       return 5'd6;
            3:       return 5'd4;
            4:       return 5'd3;
            default: return 5'd2;
        endcase
    endfunction

    logic [PROD_W-1:0] row0;
    logic [PROD_W-1:0] row1;

    always_comb begin : reduce
        logic [31:0] cur [NCOL];
        logic [31:0] nxt [NCOL];
        logic [4:0]  hc  [NCOL];
        logic [4:0]  hn  [NCOL];
        logic [4:0]  idx;
        logic [4:0]  rem;
        logic [4:0]  tot;
        logic [4:0]  d;
        logic [4:0]  c5;
        logic [4:0]  cp5;
        logic        pp;
        logic        x;
        logic        y;
        logic        z;
        logic        sb;
        logic        cy;

        row0 = '0;
        row1 = '0;
        for (int unsigned c = 0; c < NCOL; c++) begin
            cur[c] = '0;
            nxt[c] = '0;
            hc[c]  = '0;
            hn[c]  = '0;
        end
        idx = '0; rem = '0; tot = '0; d = '0; c5 = '0; cp5 = '0;
        pp = 1'b0; x = 1'b0; y = 1'b0; z = 1'b0; sb = 1'b0; cy = 1'b0;

        // Sign-row terms are inverted; the fixed ones at bits 16 and 31
        // complete the Baugh-Wooley correction modulo 2^32.
        for (int unsigned i = 0; i < OP_W; i++) begin
            for (int unsigned j = 0; j < OP_W; j++) begin
                pp = a_i[4'(i)] & b_i[4'(j)];
                if ((i == OP_W - 1) != (j == OP_W - 1)) pp = ~pp;
                c5 = 5'(i + j);
                cur[c5][hc[c5]] = pp;
                hc[c5] = hc[c5] + 5'd1;
            end
        end
        cur[5'd16][hc[5'd16]] = 1'b1;
        hc[5'd16] = hc[5'd16] + 5'd1;
        cur[5'd31][hc[5'd31]] = 1'b1;
        hc[5'd31] = hc[5'd31] + 5'd1;

        for (int unsigned s = 0; s < NSTG; s++) begin
            d = stage_h(s);
            for (int unsigned c = 0; c < NCOL; c++) begin
                nxt[c] = '0;
                hn[c]  = '0;
            end
            for (int unsigned c = 0; c < NCOL; c++) begin
                c5  = 5'(c);
                cp5 = 5'(c + 1);
                idx = '0;
                // Carries already pushed into this column count toward its height.
                for (int unsigned k = 0; k < MAXA; k++) begin
                    rem = hc[c5] - idx;
                    tot = hn[c5] + rem;
                    if (tot > d && rem >= 5'd2) begin
                        x = cur[c5][idx];
                        y = cur[c5][idx + 5'd1];
                        if (tot == d + 5'd1 || rem == 5'd2) begin
                            sb  = x ^ y;
                            cy  = x & y;
                            idx = idx + 5'd2;
                        end else begin
                            z   = cur[c5][idx + 5'd2];
                            sb  = x ^ y ^ z;
                            cy  = (x & y) | (x & z) | (y & z);
                            idx = idx + 5'd3;
                        end
                        nxt[c5][hn[c5]] = sb;
                        hn[c5] = hn[c5] + 5'd1;
                        if (c < NCOL - 1) begin
                            nxt[cp5][hn[cp5]] = cy;
                            hn[cp5] = hn[cp5] + 5'd1;
                        end
                    end
                end
                for (int unsigned r = 0; r < 32; r++) begin
                    if (5'(r) >= idx && 5'(r) < hc[c5]) begin
                        nxt[c5][hn[c5]] = cur[c5][5'(r)];
                        hn[c5] = hn[c5] + 5'd1;
                    end
                end
            end
            cur = nxt;
            hc  = hn;
        end

        for (int unsigned c = 0; c < NCOL; c++) begin
            row0[c] = (hc[c] >= 5'd1) ? cur[c][0] : 1'b0;
            row1[c] = (hc[c] >= 5'd2) ? cur[c][1] : 1'b0;
        end
    end

    assign prod_o = row0 + row1;

endmodule

// File: rtl/dadda_dot_acc.sv
// Streaming signed dot-product engine around dadda16x16 (S1 operands, S2 product, S3 accumulate).
// Define DADDA_ACC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module dadda_dot_acc
    import dadda_pkg::*;
#(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned LEN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_W-1:0]         in_a,
    input  logic [OP_W-1:0]         in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    out_ovf,
    output logic                    busy
);

`ifdef DADDA_ACC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max(ACC_W));
    localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min(ACC_W));
`endif

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [OP_W-1:0]    a1_q, b1_q;
    logic               v1_q;
    logic [PROD_W-1:0]  p2_q;
    logic               v2_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [PROD_W-1:0]  prod;
    logic [ACC_W:0]     sum_x;
    logic               sum_ovf;
    logic               accept;

    dadda16x16 u_mul (
        .a_i    (a1_q),
        .b_i    (b1_q),
        .prod_o (prod)
    );

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = cfg_len;
                    state_d = (cfg_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready = (rem_q != '0);
                if (in_valid && in_ready) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!v1_q && !v2_q) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Overflow is detected in ACC_W+1 bits: the top two bits disagree.
    always_comb begin
        sum_x   = {acc_q[ACC_W-1], acc_q}
                + {{(ACC_W + 1 - PROD_W){p2_q[PROD_W-1]}}, p2_q};
        sum_ovf = sum_x[ACC_W] ^ sum_x[ACC_W-1];
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && start) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (v2_q) begin
            acc_d = sum_x[ACC_W-1:0];
            if (sum_ovf) begin
                ovf_d = 1'b1;
`ifdef DADDA_ACC_SAT_EN
                acc_d = sum_x[ACC_W] ? ACC_MIN : ACC_MAX;
`else
                acc_d = sum_x[ACC_W-1:0];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            a1_q    <= '0;
            b1_q    <= '0;
            v1_q    <= 1'b0;
            p2_q    <= '0;
            v2_q    <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            v1_q    <= accept;
            if (accept) begin
                a1_q <= in_a;
                b1_q <= in_b;
            end
            v2_q <= v1_q;
            if (v1_q) p2_q <= prod;
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_sum = acc_q;
    assign out_ovf = ovf_q;

endmodule

// File: tb/tb_dadda_dot_acc.sv
// Randomised self-checking bench for dadda_dot_acc against a plain-arithmetic job model.
module tb_dadda_dot_acc;

    localparam int unsigned ACC_W = 32;
    localparam int unsigned LEN_W = 8;
    localparam longint AMAX = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
    localparam longint AMIN = -(64'sd1 <<< (ACC_W - 1));

    logic                    clk;
    logic                    rst_n;
    logic                    start;
    logic [LEN_W-1:0]        cfg_len;
    logic                    in_valid;
    logic                    in_ready;
    logic [15:0]             in_a;
    logic [15:0]             in_b;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic                    out_ovf;
    logic                    busy;

    int n_chk = 0;
    int n_err = 0;
    int ja [32];
    int jb [32];

    dadda_dot_acc #(
        .ACC_W (ACC_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached, got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: exact 64-bit products summed into an ACC_W-bit accumulator.
    function automatic void ref_job(input int len, output logic [31:0] esum, output bit eovf);
        longint acc;
        longint t;
        acc  = 0;
        eovf = 1'b0;
        for (int i = 0; i < len; i++) begin
            t = acc + longint'(ja[i]) * longint'(jb[i]);
            if (t > AMAX || t < AMIN) begin
                eovf = 1'b1;
`ifdef DADDA_ACC_SAT_EN
                acc = (t > AMAX) ? AMAX : AMIN;
`else
                acc = longint'(int'(t));
`endif
            end else begin
                acc = t;
            end
        end
        esum = 32'(acc);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int len, input bit gaps, input int hold, input string tag,
                           output logic [31:0] got_sum);
        logic [31:0] esum;
        bit          eovf;
        int          idx;
        int          guard;
        int          lat;
        bit          took;
        ref_job(len, esum, eovf);
        start   = 1'b1;
        cfg_len = LEN_W'(len);
        next_cycle();
        start = 1'b0;
        if (len == 0) begin
            check_eq({tag, "_zero_valid"}, 32'(out_valid), 32'd1);
            check_eq({tag, "_zero_ready"}, 32'(in_ready), 32'd0);
        end else begin
            check_eq({tag, "_busy"}, 32'(busy), 32'd1);
            idx   = 0;
            guard = 0;
            while (idx < len && guard < 400) begin
                in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                in_a     = in_valid ? 16'(ja[idx]) : 16'($urandom);
                in_b     = in_valid ? 16'(jb[idx]) : 16'($urandom);
                if (gaps) begin
                    start   = ($urandom_range(0, 3) == 0);
                    cfg_len = LEN_W'($urandom);
                end
                took = in_valid && in_ready;
                next_cycle();
                if (took) idx++;
                guard++;
            end
            in_valid = 1'b0;
            start    = 1'b0;
            check_eq({tag, "_beats"}, 32'(idx), 32'(len));
            check_eq({tag, "_ready_off"}, 32'(in_ready), 32'd0);
            lat = 0;
            while (!out_valid && lat < 20) begin
                next_cycle();
                lat++;
            end
            check_eq({tag, "_latency"}, 32'(lat), 32'd3);
        end
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            start   = (h == 1);
            cfg_len = LEN_W'(3);
            next_cycle();
            check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check_eq({tag, "_hold_sum"}, out_sum, esum);
        end
        start = 1'b0;
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_sum"}, out_sum, esum);
        check_eq({tag, "_ovf"}, 32'(out_ovf), 32'(eovf));
        got_sum   = out_sum;
        out_ready = 1'b1;
        next_cycle();
        out_ready = 1'b0;
        check_eq({tag, "_valid_off"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                ja[i] = ($urandom_range(0, 1) == 0) ? -32768 : 32767;
                jb[i] = ($urandom_range(0, 1) == 0) ? -32768 : 32767;
            end else begin
                ja[i] = $signed(16'($urandom));
                jb[i] = $signed(16'($urandom));
            end
        end
    endtask

    initial begin
        logic [31:0] got;
        int          len;
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_len   = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) next_cycle();
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_sum", out_sum, 32'd0);
        check_eq("rst_ovf", 32'(out_ovf), 32'd0);
        rst_n = 1'b1;
        next_cycle();

        ja[0] = 100;  jb[0] = 50;
        ja[1] = 100;  jb[1] = -50;
        ja[2] = -100; jb[2] = -50;
        run_job(3, 1'b0, 0, "basic", got);
        check_eq("basic_const", got, 32'd5000);

        run_job(0, 1'b0, 0, "zero", got);
        check_eq("zero_const", got, 32'd0);

        ja[0] = -32768; jb[0] = -32768;
        ja[1] = -32768; jb[1] = -32768;
        run_job(2, 1'b0, 0, "ovf", got);
`ifdef DADDA_ACC_SAT_EN
        check_eq("ovf_const", got, 32'h7FFF_FFFF);
`else
        check_eq("ovf_const", got, 32'h8000_0000);
`endif

        for (int i = 0; i < 4; i++) begin
            ja[i] = 7;
            jb[i] = -3;
        end
        run_job(4, 1'b1, 5, "hold", got);
        check_eq("hold_const", got, 32'(-84));

        fill_random(5);
        start   = 1'b1;
        cfg_len = LEN_W'(5);
        next_cycle();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_a     = 16'(ja[i]);
            in_b     = 16'(jb[i]);
            next_cycle();
        end
        in_valid = 1'b0;
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        check_eq("midrst_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_ready", 32'(in_ready), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_sum", out_sum, 32'd0);
        check_eq("midrst_ovf", 32'(out_ovf), 32'd0);
        rst_n = 1'b1;
        next_cycle();
        ja[0] = 12345;
        jb[0] = -1;
        run_job(1, 1'b0, 0, "fresh", got);
        check_eq("fresh_const", got, 32'(-12345));

        for (int j = 0; j < 25; j++) begin
            len = $urandom_range(1, 20);
            fill_random(len);
            run_job(len, 1'($urandom_range(0, 1)), $urandom_range(0, 2), "rand", got);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
